// File: rtl/jpeg_sched_pkg.sv
// jpeg_sched_pkg: shared types and encoder-wrapper constants for the JPEG stream scheduler
package jpeg_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FEED, S_HOLD, S_WAIT_END, S_ABORT} sched_state_e;
  localparam int PIXELS_PER_BLOCK = 64;
  localparam logic [8:0] DATA_FIFO = 9'h000;
  localparam logic [8:0] FIFO_DEPTH = 9'h004;
  localparam logic [8:0] END_BITS = 9'h008;
  localparam int LAST_BLOCK_BIT = 8;
endpackage

// File: rtl/jpeg_rr_arb.sv
// jpeg_rr_arb: combinational round-robin pick of the first valid requester at or after ptr_i
module jpeg_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);
  // Walk from the farthest candidate back to the pointer so the nearest valid one wins
  always_comb begin
    int r;
    r = 0;
    grant_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      r = (int'(ptr_i) + k) % NUM_REQ;
      if (valid_i[r]) begin
        grant_o = '0;
        grant_o[r] = 1'b1;
        idx_o = IDW'(r);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jpeg_stream_sched.sv
// jpeg_stream_sched: per-stream round-robin owner of the shared JPEG encoder with block sequencing and watchdog
module jpeg_stream_sched
  import jpeg_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*32-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   enc_wr_valid_o,
  output logic [31:0]            enc_wr_data_o,
  output logic                   enc_wr_last_o,
  input  logic                   enc_wr_ready_i,
  input  logic                   enc_end_i,
  input  logic                   enc_error_i,
  output logic                   busy_o,
  output logic [IDW-1:0]         owner_o,
  output logic                   done_o,
  output logic                   abort_o,
  output logic [IDW-1:0]         event_id_o
);
  localparam int WDW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  sched_state_e state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick, owner_nxt;
  logic [5:0] cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic last_q, last_d;
  logic [NUM_REQ-1:0] grant;
  logic any, own_valid, xfer, live, idle, expire;

  jpeg_rr_arb #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (pick),
    .any_o  (any)
  );

  // Datapath muxing, event outputs, watchdog and next-state selection with error > end > watchdog > transfer
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    last_d = last_q;
    cnt_d = cnt_q;
    own_valid = req_valid_i[owner_q];
    owner_nxt = owner_q == IDW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
    enc_wr_valid_o = state_q == S_FEED && own_valid;
    enc_wr_data_o = state_q == S_FEED ? req_data_i[32*owner_q +: 32] : '0;
    enc_wr_last_o = state_q == S_FEED && last_q;
    xfer = enc_wr_valid_o && enc_wr_ready_i;
    req_ready_o = '0;
    req_ready_o[owner_q] = xfer;
    busy_o = state_q != S_IDLE;
    owner_o = busy_o ? owner_q : '0;
    live = state_q inside {S_FEED, S_HOLD, S_WAIT_END};
    idle = live && !xfer && !enc_end_i;
    expire = TIMEOUT != 0 && idle && wd_q == WDW'(TIMEOUT - 1);
    done_o = state_q == S_WAIT_END && enc_end_i && !enc_error_i;
    abort_o = state_q == S_ABORT;
    event_id_o = (done_o || abort_o) ? owner_q : '0;
    if (state_q == S_IDLE) begin
      if (any) begin
        state_d = S_FEED;
        owner_d = pick;
        last_d = |(grant & req_last_i);
        cnt_d = 6'(PIXELS_PER_BLOCK - 1);
      end
    end else if (state_q == S_ABORT) begin
      state_d = S_IDLE;
      ptr_d = owner_nxt;
    end else if (enc_error_i) begin
      state_d = S_ABORT;
    end else if (done_o) begin
      state_d = S_IDLE;
      ptr_d = owner_nxt;
    end else if (expire) begin
      state_d = S_ABORT;
    end else if (xfer) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) state_d = last_q ? S_WAIT_END : S_HOLD;
    end else if (state_q == S_HOLD && own_valid) begin
      state_d = S_FEED;
      last_d = req_last_i[owner_q];
      cnt_d = 6'(PIXELS_PER_BLOCK - 1);
    end
    wd_d = (state_d != state_q || xfer) ? '0 : idle ? wd_q + 1'b1 : wd_q;
  end

  // State, ownership, block counter and watchdog registers
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      wd_q <= wd_d;
    end
  end
endmodule

// File: doc/jpeg_stream_sched.md
Name: jpeg_stream_sched

Overview:
- Shares the single JPEG encoder wrapper between NUM_REQ independent pixel-stream requesters (e.g. camera channels).
- Arbitration is per stream, round-robin. Once granted, a requester owns the encoder until its last block's end-of-stream completes, because encoder stream state is not switchable mid-stream.
- Sequences 64-pixel block bursts into the wrapper's write port and tracks end/error events.
- Aborts owners that stall, using a watchdog.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 4096: idle cycles allowed while owned before abort; 0 disables the watchdog.
- IDW, $clog2(NUM_REQ): owner id width.

Ports:
- clk  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  requester has a pixel word
- req_data_i  in  NUM_REQ*32  packed pixel words, one per requester
- req_last_i  in  NUM_REQ  current block is the last of the stream; sampled with the block's first pixel
- req_ready_o  out  NUM_REQ  pixel accepted
- enc_wr_valid_o  out  1  write request to encoder
- enc_wr_data_o  out  32  pixel word
- enc_wr_last_o  out  1  last-block flag (drives address bit 8)
- enc_wr_ready_i  in  1  encoder write grant
- enc_end_i  in  1  end-of-stream pulse from encoder
- enc_error_i  in  1  encoder FIFO-full error
- busy_o  out  1  encoder owned
- owner_o  out  IDW  current owner
- done_o  out  1  one-cycle pulse: stream completed
- abort_o  out  1  one-cycle pulse: stream aborted
- event_id_o  out  IDW  requester for done_o/abort_o

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE.
  - All outputs 0; req_ready_o=0.
  - RR pointer = 0; pixel counter = 0; watchdog = 0.
- States: IDLE, FEED, HOLD, WAIT_END, ABORT.
- IDLE:
  - If any req_valid_i, the RR arbiter picks the first valid requester at or after the pointer, wrapping.
  - Latch owner and req_last_i[owner]; go to FEED with count=63 next cycle. No pixel is consumed on the arbitration cycle.
  - Arbitration takes 1 cycle.
- FEED:
  - enc_wr_valid_o = req_valid_i[owner].
  - enc_wr_data_o = req_data_i[owner]; enc_wr_last_o = latched last.
  - req_ready_o[owner] = enc_wr_ready_i & enc_wr_valid_o. Other ready bits stay 0.
  - A transfer occurs when valid & ready in the same cycle; ready does not depend on valid from the encoder side.
  - Each transfer decrements the count. The transfer at count==0 goes to WAIT_END if last, else HOLD.
- HOLD:
  - Owner is retained.
  - On req_valid_i[owner]: re-latch req_last_i[owner], set count=63, go to FEED. No data transfer in this cycle.
  - Other requesters are ignored.
- WAIT_END: wait for enc_end_i, then done_o=1 and event_id_o=owner for 1 cycle. Pointer = owner+1 (mod NUM_REQ); go to IDLE.
- ABORT:
  - Entered from FEED/HOLD/WAIT_END on enc_error_i=1, or on watchdog expiry.
  - abort_o=1 and event_id_o=owner for 1 cycle. Pointer = owner+1; go to IDLE.
  - The encoder is not reset here; software restarts it through the end-bits read.
- Watchdog:
  - Counts cycles in FEED/HOLD/WAIT_END with no transfer and no enc_end_i.
  - Cleared on any transfer or state change.
  - Expiry when count == TIMEOUT-1 and the cycle is idle again.
- Priority when events coincide: enc_error_i > enc_end_i > watchdog > transfer.
- enc_end_i outside WAIT_END is ignored.
- busy_o = state != IDLE. owner_o is valid while busy, 0 otherwise.
- done_o and abort_o are never asserted together.
- A requester dropping valid mid-block only stalls; it does not lose its position in the block count.
- Pointer wrap: owner NUM_REQ-1 → pointer 0.

Decomposition:
- Package jpeg_sched_pkg:
  - sched_state_e enum.
  - PIXELS_PER_BLOCK=64.
  - Wrapper address constants: DATA_FIFO, FIFO_DEPTH, END_BITS, LAST_BLOCK_BIT=8.
- Sub-module jpeg_rr_arb: combinational round-robin pick from valid vector plus pointer; outputs one-hot grant and index.

Test Plan:
- Single requester 0, one block with last=1, enc_wr_ready_i always 1 → exactly 64 transfers, enc_wr_last_o=1 throughout, WAIT_END. enc_end_i at cycle 100 → done_o pulse, event_id_o=0, busy_o=0.
- Requesters 1 and 2 both valid from reset → 1 is granted first. Its 2-block stream must fully complete, with 2 ignored while 1 is in HOLD. Then 2 is granted. Requesters 1 and 3 then valid → 3 is granted (pointer=3).
- enc_wr_ready_i toggles 0/1 every cycle during FEED → 64 transfers over about 128 cycles, no data lost or duplicated; checked with incrementing pixel values 0..63.
- TIMEOUT=16, owner stops after 10 pixels → abort_o 16 idle cycles later, event_id_o=owner. The next arbitration skips past that owner.
- enc_error_i pulse during HOLD with enc_end_i in the same cycle → abort_o only, no done_o.
- rst_ni asserted mid-FEED at pixel 30 → all outputs 0 immediately. After release, a new stream starts from count 63.
